// File: rtl/load_store_unit_if.sv
// Handshake and memory bus bundle between execute stage, LSU and data memory.
// Modports: master = LSU view, slave = execute-stage/memory environment view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    input  mem_rdata, mem_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err,
    output mem_addr, mem_wdata,
    output mem_read, mem_write,
    output mem_byte_enable
  );

  modport slave (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    output mem_rdata, mem_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err,
    input  mem_addr, mem_wdata,
    input  mem_read, mem_write,
    input  mem_byte_enable
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time, RISC-V funct3 sizes, word memory.
// Ports: clk, reset_n (async low), bus (load_store_unit_if.master).
// Optional LSU_TIMEOUT_EN: WAIT aborts with error after TIMEOUT_CYCLES.
module load_store_unit
`ifdef LSU_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 15
)
`endif
(
  input logic               clk,
  input logic               reset_n,
  load_store_unit_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_RESP
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [3:0]  r_mem_be;

  logic        w_ill;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [15:0] w_sh;
  logic [31:0] w_ld;
  logic        w_to;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  // Last no-ready WAIT cycle before the limit is reached.
  assign w_to = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_to = 1'b0;
`endif

  always_comb begin
    w_mis = 1'b0;
    if (bus.req_we)
      w_ill = bus.req_funct3[2] |
              (&bus.req_funct3[1:0]);
    else
      w_ill = (&bus.req_funct3[1:0]) |
              (bus.req_funct3 == 3'd6);
    unique case (1'b1)
      (bus.req_funct3[1:0] == 2'b01):
        w_mis = bus.req_addr[0];
      (bus.req_funct3[1:0] == 2'b10):
        w_mis = |bus.req_addr[1:0];
      default: w_mis = 1'b0;
    endcase
  end

  always_comb begin
    w_be = 4'b1111;
    w_wd = bus.req_wdata;
    unique case (1'b1)
      (bus.req_funct3[1:0] == 2'b00): begin
        w_be = 4'b0001 << bus.req_addr[1:0];
        w_wd = {4{bus.req_wdata[7:0]}};
      end
      (bus.req_funct3[1:0] == 2'b01): begin
        w_be = 4'b0011 << {bus.req_addr[1], 1'b0};
        w_wd = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_sh = 16'(bus.mem_rdata >> {r_off, 3'b000});

  always_comb begin
    case (r_f3)
      3'd0:    w_ld = {{24{w_sh[7]}}, w_sh[7:0]};
      3'd4:    w_ld = {24'd0, w_sh[7:0]};
      3'd1:    w_ld = {{16{w_sh[15]}}, w_sh};
      3'd5:    w_ld = {16'd0, w_sh};
      default: w_ld = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_f3         <= 3'd0;
      r_off        <= 2'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_be     <= '0;
`ifdef LSU_TIMEOUT_EN
      r_cnt        <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_f3        <= bus.req_funct3;
            r_off       <= bus.req_addr[1:0];
            r_req_ready <= 1'b0;
            if (w_ill | w_mis) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state     <= S_REQ;
              r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
              r_mem_read  <= ~bus.req_we;
              r_mem_write <= bus.req_we;
              r_mem_be    <= bus.req_we ? w_be : 4'b0000;
              r_mem_wdata <= bus.req_we ? w_wd : '0;
            end
          end
        end
        S_REQ: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_state     <= S_WAIT;
`ifdef LSU_TIMEOUT_EN
          r_cnt       <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.mem_ready) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_we ? '0 : w_ld;
          end else if (w_to) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end
`ifdef LSU_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_req_ready  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready       = r_req_ready;
  assign bus.resp_valid      = r_resp_valid;
  assign bus.resp_rdata      = r_resp_rdata;
  assign bus.resp_err        = r_resp_err;
  assign bus.mem_addr        = r_mem_addr;
  assign bus.mem_wdata       = r_mem_wdata;
  assign bus.mem_read        = r_mem_read;
  assign bus.mem_write       = r_mem_write;
  assign bus.mem_byte_enable = r_mem_be;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory,
// randomized accesses, per-cycle bus/response compare, directed cases.
module tb_load_store_unit;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit          we;
    bit [2:0]    f3;
    bit [31:0]   addr;
    bit          strobe;
    bit          err;
    bit [31:0]   rd;
    int          lat;
    bit [3:0]    be;
    bit [31:0]   mwd;
    longint      t;
  } exp_t;

  int checks = 0;
  int failures = 0;

  exp_t q[$];
  bit   head_seen = 1'b0;
  bit   mon_en = 1'b0;
  int   resp_count = 0;
  logic [31:0] last_rd;
  logic        last_err;
  int          last_lat;
  logic [3:0]  last_be;
  logic [31:0] last_mwd;
  logic [31:0] last_maddr;

  logic [7:0]  ref_b [256];
  logic [31:0] bfm [64];
  int next_delay = 0;
  bit next_noise = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s bound expired", nm);
  endtask

  // Reference: spec rules on a byte-addressed memory.
  function automatic exp_t model(bit we, bit [2:0] f3,
                                 bit [31:0] addr,
                                 bit [31:0] wd, int d);
    exp_t e;
    int n;
    bit legal;
    bit [31:0] v;
    e.we = we; e.f3 = f3; e.addr = addr; e.t = 0;
    n = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) :
                 (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.strobe = legal && ((addr % n) == 0);
    e.err = !e.strobe;
    e.be = '0; e.mwd = '0; e.rd = '0; e.lat = 1;
    if (e.strobe) begin
      e.lat = 3 + d;
`ifdef LSU_TIMEOUT_EN
      if (d >= TO) begin
        e.err = 1'b1;
        e.lat = 2 + TO;
      end
`endif
      if (we) begin
        for (int i = 0; i < n; i++) begin
          e.be[(addr % 4) + i] = 1'b1;
          ref_b[(addr + i) % 256] = wd[8*i +: 8];
        end
        for (int j = 0; j < 4; j++)
          e.mwd[8*j +: 8] = wd[8*(j % n) +: 8];
      end else if (!e.err) begin
        v = '0;
        for (int i = 0; i < n; i++)
          v[8*i +: 8] = ref_b[(addr + i) % 256];
        if (n < 4 && !f3[2] && v[8*n-1])
          for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
        e.rd = v;
      end
    end
    return e;
  endfunction

  // Data memory: registered read, ready after 1+delay cycles.
  initial begin
    int pend;
    logic [31:0] cap;
    logic [5:0] wi;
    pend = 0;
    cap = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = cap;
        end
      end
      if (bus.mem_read || bus.mem_write) begin
        wi = bus.mem_addr[7:2];
        if (bus.mem_write)
          for (int b = 0; b < 4; b++)
            if (bus.mem_byte_enable[b])
              bfm[wi][8*b +: 8] = bus.mem_wdata[8*b +: 8];
        cap = bfm[wi];
        pend = 1 + next_delay;
        if (next_noise) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = $urandom();
        end
      end
    end
  end

  // Per-cycle compare against the queued expectations.
  always @(negedge clk) begin
    exp_t e;
    int idx;
    if (reset_n && mon_en) begin
      chk("req_ready", bus.req_ready, q.size() == 0);
      chk("rd_wr_excl", bus.mem_read & bus.mem_write, 0);
      if (bus.mem_read || bus.mem_write) begin
        chk("strobe_pending", q.size(), 1);
        if (q.size() != 0) begin
          e = q[0];
          idx = int'((longint'($time) - e.t + 5) / 10);
          chk("strobe_expected", e.strobe, 1);
          chk("strobe_cycle", idx, 1);
          chk("mem_read", bus.mem_read, !e.we);
          chk("mem_write", bus.mem_write, e.we);
          chk("mem_addr", bus.mem_addr,
              {e.addr[31:2], 2'b00});
          chk("mem_be", bus.mem_byte_enable, e.be);
          if (e.we) chk("mem_wdata", bus.mem_wdata, e.mwd);
          head_seen = 1'b1;
          last_be = bus.mem_byte_enable;
          last_mwd = bus.mem_wdata;
          last_maddr = bus.mem_addr;
        end
      end
      if (bus.resp_valid) begin
        chk("resp_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          idx = int'((longint'($time) - e.t + 5) / 10);
          chk("resp_err", bus.resp_err, e.err);
          chk("resp_rdata", bus.resp_rdata, e.rd);
          chk("resp_latency", idx, e.lat);
          chk("strobe_seen", head_seen, e.strobe);
          head_seen = 1'b0;
          last_rd = bus.resp_rdata;
          last_err = bus.resp_err;
          last_lat = idx;
          resp_count++;
        end
      end else begin
        chk("idle_rdata", bus.resp_rdata, 0);
        chk("idle_err", bus.resp_err, 0);
      end
    end
  end

  task automatic access(input bit we, input bit [2:0] f3,
                        input bit [31:0] addr,
                        input bit [31:0] wd, input int d,
                        input bit junk, input bit noise,
                        input bit wait_resp);
    bit ok;
    int rc;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #2;
      if (bus.req_ready) ok = 1'b1;
    end
    if (!ok) begin
      fail("req_ready_wait");
      return;
    end
    next_delay = d;
    next_noise = noise;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    e = model(we, f3, addr, wd, d);
    e.t = longint'($time);
    q.push_back(e);
    rc = resp_count;
    #1;
    if (junk) begin
      bus.req_we = 1'($urandom());
      bus.req_funct3 = 3'($urandom());
      bus.req_addr = $urandom();
      bus.req_wdata = $urandom();
    end else begin
      bus.req_valid = 1'b0;
    end
    if (wait_resp) begin
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
        @(negedge clk);
        #2;
        if (resp_count != rc) ok = 1'b1;
      end
      bus.req_valid = 1'b0;
      if (!ok) begin
        fail("resp_wait");
        q.delete();
        head_seen = 1'b0;
      end
    end
  endtask

  task automatic go(input bit we, input bit [2:0] f3,
                    input bit [31:0] addr,
                    input bit [31:0] wd, input int d);
    access(we, f3, addr, wd, d, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bit [31:0] a;
    bit [2:0] f;
    int n;
    for (int i = 0; i < 256; i++) ref_b[i] = 8'($urandom());
    for (int w = 0; w < 64; w++)
      bfm[w] = {ref_b[4*w+3], ref_b[4*w+2],
                ref_b[4*w+1], ref_b[4*w]};
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    reset_n = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_mem_strobes",
        {bus.mem_read, bus.mem_write}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    reset_n = 1'b1;
    mon_en = 1'b1;

    go(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    chk("sw_be", last_be, 4'b1111);
    chk("sw_addr", last_maddr, 32'h10);
    chk("sw_lat", last_lat, 3);
    go(1'b0, 3'd2, 32'h10, 0, 0);
    chk("lw_data", last_rd, 32'hDEADBEEF);
    chk("lw_err", last_err, 0);
    chk("lw_lat", last_lat, 3);

    go(1'b1, 3'd0, 32'h21, 32'h000000A5, 0);
    chk("sb_be", last_be, 4'b0010);
    chk("sb_wdata", last_mwd, 32'hA5A5A5A5);
    go(1'b0, 3'd0, 32'h21, 0, 0);
    chk("lb_data", last_rd, 32'hFFFFFFA5);
    go(1'b0, 3'd4, 32'h21, 0, 0);
    chk("lbu_data", last_rd, 32'h000000A5);

    go(1'b1, 3'd2, 32'h30, 32'h80017F00, 0);
    go(1'b0, 3'd1, 32'h32, 0, 0);
    chk("lh_hi", last_rd, 32'hFFFF8001);
    go(1'b0, 3'd5, 32'h32, 0, 0);
    chk("lhu_hi", last_rd, 32'h00008001);
    go(1'b0, 3'd1, 32'h30, 0, 0);
    chk("lh_lo", last_rd, 32'h00007F00);

    go(1'b0, 3'd2, 32'h6, 0, 0);
    chk("lw_mis_err", last_err, 1);
    chk("lw_mis_lat", last_lat, 1);
    go(1'b1, 3'd1, 32'h3, 32'h1234, 0);
    chk("sh_mis_err", last_err, 1);
    chk("sh_mis_lat", last_lat, 1);
    go(1'b0, 3'd3, 32'h40, 0, 0);
    chk("ill_err", last_err, 1);
    chk("ill_rdata", last_rd, 0);
    chk("ill_lat", last_lat, 1);

    go(1'b0, 3'd2, 32'h10, 0, 2);
    chk("lw_delay_lat", last_lat, 5);

    // Abort a load in WAIT; its late mem_ready lands in IDLE.
    access(1'b0, 3'd2, 32'h10, 0, 5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_req_ready", bus.req_ready, 1);
    chk("ar_resp_valid", bus.resp_valid, 0);
    chk("ar_strobes", {bus.mem_read, bus.mem_write}, 0);
    chk("ar_mem_addr", bus.mem_addr, 0);
    chk("ar_mem_be", bus.mem_byte_enable, 0);
    chk("ar_mem_wdata", bus.mem_wdata, 0);
    chk("ar_rdata", bus.resp_rdata, 0);
    q.delete();
    head_seen = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    go(1'b0, 3'd2, 32'h10, 0, 0);
    chk("post_rst_lw", last_rd, 32'hDEADBEEF);

    for (int k = 0; k < 250; k++) begin
      f = 3'($urandom_range(0, 7));
      n = 1 << f[1:0];
      a = ($urandom_range(0, 3) == 0) ? $urandom() :
          32'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0 && n <= 4)
        a = a & ~(32'(n) - 1);
      access(1'($urandom()), f, a, $urandom(),
             ($urandom_range(0, 3) == 0) ?
               $urandom_range(0, 3) : 0,
             1'($urandom()),
             $urandom_range(0, 3) == 0, 1'b1);
    end

`ifdef LSU_TIMEOUT_EN
    go(1'b1, 3'd2, 32'h44, 32'h12345678, TO - 1);
    chk("to_edge_err", last_err, 0);
    chk("to_edge_lat", last_lat, 17);
    go(1'b0, 3'd2, 32'h44, 0, TO);
    chk("to_err", last_err, 1);
    chk("to_rdata", last_rd, 0);
    chk("to_lat", last_lat, 17);
    repeat (10) @(negedge clk);
    go(1'b0, 3'd2, 32'h44, 0, 20);
    chk("to_late_err", last_err, 1);
    repeat (12) @(negedge clk);
    go(1'b0, 3'd2, 32'h44, 0, 0);
    chk("to_after_lw", last_rd, 32'h12345678);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
